// File: rtl/lc3b_evict_buffer_if.sv
// Cache/memory-facing bundle for the eviction buffer: push, lookup, drain and status.
// The slave view belongs to the buffer; the master view belongs to the cache/memory side.
interface lc3b_evict_buffer_if #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic [LINE_W-1:0] push_data;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_data;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  push_valid, push_addr, push_data, lookup_addr, pmem_resp,
    output push_ready, lookup_hit, lookup_data, pmem_write, pmem_address,
           pmem_wdata, empty, full, count
  );

  modport master (
    output push_valid, push_addr, push_data, lookup_addr, pmem_resp,
    input  push_ready, lookup_hit, lookup_data, pmem_write, pmem_address,
           pmem_wdata, empty, full, count
  );
endinterface

// File: rtl/lc3b_evict_buffer.sv
// Victim FIFO between L1 D-cache and memory; coalesces repeat evictions, 1-cycle push-to-write when empty.
// Backpressure: push_ready = !full from registered state; head held on pmem_* until pmem_resp.
module lc3b_evict_buffer #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  lc3b_evict_buffer_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              empty;
  logic              full;
  logic              push_acc;
  logic              pop;
  logic              alloc;
  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;
  logic [PTR_W-1:0]  lk_idx;
  logic              lk_hit;
  logic [LINE_W-1:0] lk_data;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign push_acc = bus.push_valid && !full;
  assign pop      = bus.pmem_resp && !empty;
  assign alloc    = push_acc && !coal_hit;

  assign bus.push_ready   = !full;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.count        = count_q;
  assign bus.pmem_write   = !empty;
  assign bus.pmem_address = addr_q[head_q];
  assign bus.pmem_wdata   = data_q[head_q];
  assign bus.lookup_hit   = lk_hit;
  assign bus.lookup_data  = lk_data;

  // Any valid head is being written to memory, so its data is frozen and never a coalesce target.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == bus.push_addr) && (PTR_W'(i) != head_q)) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  // Walk oldest to youngest so the entry nearest tail overrides earlier matches.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && vld_q[lk_idx] && (addr_q[lk_idx] == bus.lookup_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      case ({alloc, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= bus.push_addr;
      data_q[tail_q] <= bus.push_data;
    end else if (push_acc && coal_hit) begin
      data_q[coal_idx] <= bus.push_data;
    end
  end
endmodule

// File: tb/tb_lc3b_evict_buffer.sv
// Directed plus random bench for lc3b_evict_buffer against a queue-based model of the victim buffer.
module tb_lc3b_evict_buffer;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lc3b_evict_buffer_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  lc3b_evict_buffer #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: queue index 0 is the oldest entry (the one being written to memory).
  logic [ADDR_W-1:0] qa [$];
  logic [LINE_W-1:0] qd [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic              lh;
    logic [LINE_W-1:0] ld;
    int                sz;
    sz = qa.size();
    lh = 1'b0;
    ld = '0;
    for (int i = 0; i < sz; i++) begin
      if (qa[i] == bus.lookup_addr) begin
        lh = 1'b1;
        ld = qd[i];
      end
    end
    chk("count", 128'(bus.count), 128'(sz));
    chk("empty", 128'(bus.empty), 128'(sz == 0));
    chk("full", 128'(bus.full), 128'(sz == DEPTH));
    chk("push_ready", 128'(bus.push_ready), 128'(sz < DEPTH));
    chk("pmem_write", 128'(bus.pmem_write), 128'(sz > 0));
    if (sz > 0) begin
      chk("pmem_address", 128'(bus.pmem_address), 128'(qa[0]));
      chk("pmem_wdata", bus.pmem_wdata, qd[0]);
    end
    chk("lookup_hit", 128'(bus.lookup_hit), 128'(lh));
    chk("lookup_data", bus.lookup_data, ld);
  endtask

  task automatic model_update(input logic pv, input logic [ADDR_W-1:0] pa,
                              input logic [LINE_W-1:0] pd, input logic rs);
    int sz0;
    int idx;
    sz0 = qa.size();
    if (pv && sz0 < DEPTH) begin
      idx = -1;
      for (int i = 1; i < sz0; i++)
        if (qa[i] == pa) idx = i;
      if (idx >= 0) begin
        qd[idx] = pd;
      end else begin
        qa.push_back(pa);
        qd.push_back(pd);
      end
    end
    if (rs && sz0 > 0) begin
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
  endtask

  // Called just after a rising edge: drive, check settled outputs, clock, update model.
  task automatic step(input logic pv, input logic [ADDR_W-1:0] pa, input logic [LINE_W-1:0] pd,
                      input logic rs, input logic [ADDR_W-1:0] la);
    bus.push_valid  = pv;
    bus.push_addr   = pa;
    bus.push_data   = pd;
    bus.pmem_resp   = rs;
    bus.lookup_addr = la;
    #1;
    check_model();
    @(posedge clk);
    model_update(pv, pa, pd, rs);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 3 * DEPTH && qa.size() > 0; n++)
      step(1'b0, '0, '0, 1'b1, '0);
    chk("drain_done", 128'(bus.empty), 128'(1));
  endtask

  localparam logic [LINE_W-1:0] DA5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] D1  = {4{32'h1111_0001}};
  localparam logic [LINE_W-1:0] D2  = {4{32'h2222_0002}};
  localparam logic [LINE_W-1:0] D3  = {4{32'h3333_0003}};

  initial begin
    reset_n         = 1'b0;
    bus.push_valid  = 1'b0;
    bus.push_addr   = '0;
    bus.push_data   = '0;
    bus.pmem_resp   = 1'b0;
    bus.lookup_addr = '0;
    #12;
    check_model();
    chk("rst_push_ready", 128'(bus.push_ready), 128'(1));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single line through the buffer, one-cycle push-to-write latency.
    step(1'b1, 12'h012, DA5, 1'b0, 12'h012);
    bus.push_valid = 1'b0;
    #1;
    chk("lat_pmem_write", 128'(bus.pmem_write), 128'(1));
    chk("lat_pmem_address", 128'(bus.pmem_address), 128'(12'h012));
    step(1'b0, '0, '0, 1'b1, 12'h012);
    step(1'b0, '0, '0, 1'b0, 12'h012);

    // Fill with memory stalled, then drain in order across the pointer wrap.
    for (int i = 1; i <= DEPTH; i++)
      step(1'b1, ADDR_W'(16 * i), {4{32'(i)}}, 1'b0, 12'h010);
    chk("fill_full", 128'(bus.full), 128'(1));
    step(1'b1, 12'h070, D1, 1'b0, 12'h070);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("wrap_order", 128'(bus.pmem_address), 128'(ADDR_W'(16 * i)));
      step(1'b0, '0, '0, 1'b1, 12'h040);
    end
    step(1'b0, '0, '0, 1'b0, 12'h040);

    // Coalesce onto a non-head entry.
    step(1'b1, 12'h020, D1, 1'b0, 12'h030);
    step(1'b1, 12'h030, D2, 1'b0, 12'h030);
    step(1'b1, 12'h030, D3, 1'b0, 12'h030);
    step(1'b0, '0, '0, 1'b0, 12'h030);
    chk("coal_data", bus.lookup_data, D3);
    drain();

    // Same address as the in-flight head allocates a new entry.
    step(1'b1, 12'h050, D1, 1'b0, 12'h050);
    step(1'b1, 12'h050, D2, 1'b0, 12'h050);
    step(1'b0, '0, '0, 1'b0, 12'h050);
    chk("head_frozen", bus.pmem_wdata, D1);
    chk("head_young_lookup", bus.lookup_data, D2);
    step(1'b0, '0, '0, 1'b1, 12'h050);
    step(1'b0, '0, '0, 1'b0, 12'h050);
    drain();

    // Push and pop in the same cycle at count 3.
    step(1'b1, 12'h101, D1, 1'b0, 12'h101);
    step(1'b1, 12'h102, D2, 1'b0, 12'h101);
    step(1'b1, 12'h103, D3, 1'b0, 12'h101);
    step(1'b1, 12'h104, DA5, 1'b1, 12'h101);
    step(1'b0, '0, '0, 1'b0, 12'h101);
    chk("pushpop_count", 128'(bus.count), 128'(3));
    drain();

    // Asynchronous reset with a write in flight; a stray response afterwards is ignored.
    step(1'b1, 12'h0A0, D1, 1'b0, 12'h0A0);
    step(1'b1, 12'h0B0, D2, 1'b0, 12'h0A0);
    #2;
    reset_n = 1'b0;
    #1;
    qa.delete();
    qd.delete();
    chk("arst_pmem_write", 128'(bus.pmem_write), 128'(0));
    check_model();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b0, '0, '0, 1'b1, 12'h0A0);
    step(1'b0, '0, '0, 1'b0, 12'h0A0);

    // Random traffic over a small address pool to exercise coalescing and wrap.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 6),
           12'h200 + ADDR_W'($urandom_range(0, 5)),
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 2) == 0),
           12'h200 + ADDR_W'($urandom_range(0, 6)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
